// File: rtl/minimax_mem_arbiter.sv
// Single-port RAM arbiter for minimax: host > data > fetch, with a fetch-starvation promotion.
// Optional exit register on the data port is enabled by defining MINIMAX_MEM_EXIT_EN.
module minimax_mem_arbiter #(
  parameter int unsigned PC_BITS   = 14,
  parameter int unsigned MAX_WAIT  = 4,
  parameter logic [31:0] EXIT_ADDR = 32'hFFFFFFFC
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic               if_req,
  input  logic [PC_BITS-1:0] if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [15:0]        if_rdata,

  input  logic               d_req,
  input  logic               d_we,
  input  logic [3:0]         d_wmask,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,

  input  logic               h_req,
  input  logic               h_we,
  input  logic [PC_BITS-1:0] h_addr,
  input  logic [31:0]        h_wdata,
  output logic               h_gnt,
  output logic               h_rvalid,
  output logic [31:0]        h_rdata,

  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [PC_BITS-3:0] ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,

  output logic               exit_valid,
  output logic [31:0]        exit_code
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_HOST  = 2'd3
  } owner_e;

  owner_e      owner, owner_nxt;
  logic [3:0]  starve_cnt;
  logic        promote;
  logic        if_sel;
  logic        d_zero, d_zero_nxt;
  logic        d_in_range;
  logic        d_exit_addr;
  logic [15:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] h_rdata_q;
  logic        unused_bits;

  assign d_in_range = (d_addr >> PC_BITS) == 32'd0;

`ifdef MINIMAX_MEM_EXIT_EN
  assign d_exit_addr = (d_addr == EXIT_ADDR);
`else
  assign d_exit_addr = 1'b0;
`endif

  // Byte-offset bits are don't-care on every port.
  assign unused_bits = ^{if_addr[0], h_addr[1:0], d_addr[1:0], EXIT_ADDR};

  assign promote = if_req && (starve_cnt == MAX_WAIT_C);

  // Grant selection and RAM port drive; read ownership is decided here and captured below.
  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    h_gnt      = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 4'h0;
    ram_addr   = '0;
    ram_wdata  = '0;
    owner_nxt  = OWN_NONE;
    d_zero_nxt = 1'b0;
    if (reset_n) begin
      if (h_req) begin
        h_gnt     = 1'b1;
        ram_en    = 1'b1;
        ram_we    = h_we ? 4'hF : 4'h0;
        ram_addr  = h_addr[PC_BITS-1:2];
        ram_wdata = h_wdata;
        owner_nxt = h_we ? OWN_NONE : OWN_HOST;
      end else if (d_req && !promote) begin
        d_gnt      = 1'b1;
        ram_en     = d_in_range && !d_exit_addr;
        ram_we     = (d_in_range && !d_exit_addr && d_we) ? d_wmask : 4'h0;
        ram_addr   = d_addr[PC_BITS-1:2];
        ram_wdata  = d_wdata;
        owner_nxt  = d_we ? OWN_NONE : OWN_DATA;
        d_zero_nxt = !(d_in_range && !d_exit_addr);
      end else if (if_req) begin
        if_gnt    = 1'b1;
        ram_en    = 1'b1;
        ram_addr  = if_addr[PC_BITS-1:2];
        owner_nxt = OWN_FETCH;
      end
    end
  end

  // Starvation counter, read-owner tag and held read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
      owner      <= OWN_NONE;
      if_sel     <= 1'b0;
      d_zero     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      h_rdata_q  <= '0;
    end else begin
      if (!if_req || if_gnt) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != MAX_WAIT_C) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      owner  <= owner_nxt;
      d_zero <= d_zero_nxt;
      if (if_gnt) begin
        if_sel <= if_addr[1];
      end
      if (if_rvalid) begin
        if_rdata_q <= if_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= d_rdata;
      end
      if (h_rvalid) begin
        h_rdata_q <= h_rdata;
      end
    end
  end

  // Returned data comes straight from the RAM in the owner's valid cycle, else the held copy.
  assign if_rvalid = (owner == OWN_FETCH);
  assign d_rvalid  = (owner == OWN_DATA);
  assign h_rvalid  = (owner == OWN_HOST);

  assign if_rdata = if_rvalid ? (if_sel ? ram_rdata[31:16] : ram_rdata[15:0]) : if_rdata_q;
  assign d_rdata  = d_rvalid ? (d_zero ? 32'd0 : ram_rdata) : d_rdata_q;
  assign h_rdata  = h_rvalid ? ram_rdata : h_rdata_q;

`ifdef MINIMAX_MEM_EXIT_EN
  // Exit register: a data write to EXIT_ADDR is absorbed here instead of reaching RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exit_valid <= 1'b0;
      exit_code  <= '0;
    end else begin
      exit_valid <= d_gnt && d_we && d_exit_addr;
      if (d_gnt && d_we && d_exit_addr) begin
        exit_code <= d_wdata;
      end
    end
  end
`else
  assign exit_valid = 1'b0;
  assign exit_code  = '0;
`endif

endmodule

// File: tb/tb_minimax_mem_arbiter.sv
// Scoreboard bench for minimax_mem_arbiter: directed scenarios followed by random traffic,
// checked against a word-array memory model and the arbitration rules.
module tb_minimax_mem_arbiter;

  localparam int unsigned PC_BITS   = 14;
  localparam int unsigned MAX_WAIT  = 4;
  localparam logic [31:0] EXIT_ADDR = 32'hFFFFFFFC;
  localparam int unsigned DEPTH     = 1 << (PC_BITS - 2);

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               if_req = 1'b0;
  logic [PC_BITS-1:0] if_addr = '0;
  logic               if_gnt, if_rvalid;
  logic [15:0]        if_rdata;
  logic               d_req = 1'b0, d_we = 1'b0;
  logic [3:0]         d_wmask = 4'h0;
  logic [31:0]        d_addr = '0, d_wdata = '0;
  logic               d_gnt, d_rvalid;
  logic [31:0]        d_rdata;
  logic               h_req = 1'b0, h_we = 1'b0;
  logic [PC_BITS-1:0] h_addr = '0;
  logic [31:0]        h_wdata = '0;
  logic               h_gnt, h_rvalid;
  logic [31:0]        h_rdata;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [PC_BITS-3:0] ram_addr;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata = '0;
  logic               exit_valid;
  logic [31:0]        exit_code;

  always #5 clk = ~clk;

  minimax_mem_arbiter #(.PC_BITS(PC_BITS), .MAX_WAIT(MAX_WAIT), .EXIT_ADDR(EXIT_ADDR)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .exit_valid(exit_valid), .exit_code(exit_code)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'hBEEF1234;
    if (i == 4) return 32'h11223344;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5AA5A5;
  endfunction

  // Synchronous single-port RAM the arbiter is attached to.
  logic [31:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_en) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
        if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic [31:0] ref_mem [DEPTH];
  exp_t        q_if[$], q_d[$], q_h[$], q_x[$];
  logic [31:0] last_if = '0, last_d = '0, last_h = '0, last_x = '0;
  int          model_starve = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [2:0]  last_gnt = '0;
  logic [2:0]  dut_gnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, 64'({if_gnt, d_gnt, h_gnt, if_rvalid, d_rvalid, h_rvalid, ram_en, ram_we, exit_valid}), 64'd0);
    check({tag, "_rd"}, 64'({if_rdata, d_rdata}), 64'd0);
    check({tag, "_hx"}, {h_rdata, exit_code}, 64'd0);
    check({tag, "_ram"}, 64'({ram_addr, ram_wdata}), 64'd0);
  endtask

  // One clock of arbitration checking against the rule model; optional reset pulse before the edge.
  task automatic cycle(input bit pulse_rst);
    logic eh, ed, ef, promote, oor, xa, en;
    logic [3:0]  we;
    logic [31:0] word;
    int hw, dw, fw;
    @(negedge clk);
    promote = if_req && (model_starve == int'(MAX_WAIT));
    eh = h_req;
    ed = d_req && !h_req && !promote;
    ef = if_req && !h_req && (!d_req || promote);
    dut_gnt = {h_gnt, d_gnt, if_gnt};
    check("gnt", 64'(dut_gnt), 64'({eh, ed, ef}));
    hw = int'(h_addr) / 4;
    dw = int'(d_addr[PC_BITS-1:0]) / 4;
    fw = int'(if_addr) / 4;
    oor = (d_addr >> PC_BITS) != 32'd0;
    xa = 1'b0;
`ifdef MINIMAX_MEM_EXIT_EN
    xa = (d_addr == EXIT_ADDR);
`endif
    en = eh || ef || (ed && !oor && !xa);
    we = 4'h0;
    if (eh && h_we) we = 4'hF;
    else if (ed && en && d_we) we = d_wmask;
    check("ram_ctl", 64'({ram_en, ram_we}), 64'({en, we}));
    if (en) check("ram_addr", 64'(ram_addr), eh ? 64'(hw) : (ed ? 64'(dw) : 64'(fw)));
    if (we != 4'h0) check("ram_wdata", 64'(ram_wdata), eh ? 64'(h_wdata) : 64'(d_wdata));
    if (eh) begin
      if (h_we) ref_mem[hw] = h_wdata;
      else q_h.push_back('{cyc + 1, ref_mem[hw]});
    end else if (ed) begin
      if (d_we) begin
        if (xa) q_x.push_back('{cyc + 1, d_wdata});
        else if (!oor)
          for (int b = 0; b < 4; b++)
            if (d_wmask[b]) ref_mem[dw][8*b +: 8] = d_wdata[8*b +: 8];
      end else begin
        q_d.push_back('{cyc + 1, (oor || xa) ? 32'd0 : ref_mem[dw]});
      end
    end else if (ef) begin
      word = ref_mem[fw];
      q_if.push_back('{cyc + 1, if_addr[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]}});
    end
    if (!if_req || ef) model_starve = 0;
    else if (model_starve < int'(MAX_WAIT)) model_starve++;
    last_gnt = {eh, ed, ef};
    if (pulse_rst) begin
      #1;
      reset_n = 1'b0;
      if_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
      #1;
      check_quiet("mid_rst");
      #1;
      reset_n = 1'b1;
      q_if.delete(); q_d.delete(); q_h.delete(); q_x.delete();
      model_starve = 0;
      last_if = '0; last_d = '0; last_h = '0; last_x = '0;
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops whatever is due this cycle and checks valids and held data.
  initial begin
    logic due;
    exp_t e;
    forever begin
      @(negedge clk);
      due = q_if.size() > 0 && q_if[0].due == cyc;
      check("if_rvalid", 64'(if_rvalid), 64'(due));
      if (due) begin e = q_if.pop_front(); last_if = e.data; end
      check("if_rdata", 64'(if_rdata), 64'(last_if));
      due = q_d.size() > 0 && q_d[0].due == cyc;
      check("d_rvalid", 64'(d_rvalid), 64'(due));
      if (due) begin e = q_d.pop_front(); last_d = e.data; end
      check("d_rdata", 64'(d_rdata), 64'(last_d));
      due = q_h.size() > 0 && q_h[0].due == cyc;
      check("h_rvalid", 64'(h_rvalid), 64'(due));
      if (due) begin e = q_h.pop_front(); last_h = e.data; end
      check("h_rdata", 64'(h_rdata), 64'(last_h));
`ifdef MINIMAX_MEM_EXIT_EN
      due = q_x.size() > 0 && q_x[0].due == cyc;
      check("exit_valid", 64'(exit_valid), 64'(due));
      if (due) begin e = q_x.pop_front(); last_x = e.data; end
      check("exit_code", 64'(exit_code), 64'(last_x));
`else
      check("exit_off", 64'({exit_valid, exit_code}), 64'd0);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] order;
    logic [9:0] fpat;
    order = '0;
    fpat = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);

    // Requests asserted during reset must not be granted.
    if_req = 1'b1; d_req = 1'b1; h_req = 1'b1;
    d_addr = 32'h10; h_addr = 14'h0008; if_addr = 14'h0004;
    @(negedge clk); @(negedge clk); #1;
    check_quiet("reset");
    if_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle(0);

    // Fetch of the upper halfword.
    if_req = 1'b1; if_addr = 14'h0006;
    cycle(0);
    if_req = 1'b0;
    check("fetch_direct", 64'({if_rvalid, if_rdata}), 64'({1'b1, 16'hBEEF}));
    cycle(0);

    // Masked write then read back.
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0011; d_addr = 32'h10; d_wdata = 32'hAABBCCDD;
    #1;
    check("wr_direct", 64'({ram_we, ram_addr}), 64'({4'b0011, 12'd4}));
    cycle(0);
    d_we = 1'b0;
    cycle(0);
    d_req = 1'b0;
    check("rd_direct", 64'({d_rvalid, d_rdata}), 64'({1'b1, 32'h1122CCDD}));
    cycle(0);

    // All three request together.
    if_req = 1'b1; if_addr = 14'h0006;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    h_req = 1'b1; h_we = 1'b0; h_addr = 14'h0004;
    for (int i = 0; i < 3; i++) begin
      cycle(0);
      order = {order[5:0], dut_gnt};
      if (last_gnt[2]) h_req = 1'b0;
      if (last_gnt[1]) d_req = 1'b0;
      if (last_gnt[0]) if_req = 1'b0;
    end
    check("triple_order", 64'(order), 64'(9'b100_010_001));
    cycle(0);

    // Fetch starvation promotion with data hogging the port.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    if_req = 1'b1; if_addr = 14'h0000;
    for (int i = 0; i < 10; i++) begin
      cycle(0);
      fpat[i] = dut_gnt[0];
    end
    check("starve_pattern", 64'(fpat), 64'(10'b10000_10000));
    d_req = 1'b0; if_req = 1'b0;
    cycle(0);

    // Reset while a data read is in flight.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    cycle(1);
    check("post_rst_direct", 64'({d_rvalid, d_rdata}), 64'd0);
    cycle(0);
    cycle(0);

    // Exit-address writes and read.
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF; d_addr = EXIT_ADDR; d_wdata = 32'h0;
    #1;
    check("exit_ram_en", 64'(ram_en), 64'd0);
    cycle(0);
`ifdef MINIMAX_MEM_EXIT_EN
    check("exit_direct0", 64'({exit_valid, exit_code}), 64'({1'b1, 32'h0}));
`else
    check("exit_off0", 64'({exit_valid, exit_code}), 64'd0);
`endif
    d_wdata = 32'hFFFFFFFF;
    cycle(0);
    d_req = 1'b0;
`ifdef MINIMAX_MEM_EXIT_EN
    check("exit_direct1", 64'({exit_valid, exit_code}), 64'({1'b1, 32'hFFFFFFFF}));
`else
    check("exit_off1", 64'({exit_valid, exit_code}), 64'd0);
`endif
    cycle(0);
    d_req = 1'b1; d_we = 1'b0;
    cycle(0);
    d_req = 1'b0;
    check("exit_rd_direct", 64'({d_rvalid, d_rdata}), 64'({1'b1, 32'h0}));
    cycle(0);

    // Random traffic; each requester holds its request until granted.
    for (int n = 0; n < 600; n++) begin
      if (!if_req && $urandom_range(0, 3) != 0) begin
        if_req = 1'b1;
        if_addr = PC_BITS'($urandom_range(0, 63));
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_wmask = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
        case ($urandom_range(0, 9))
          0:       d_addr = $urandom | (32'd1 << PC_BITS);
          1:       d_addr = EXIT_ADDR;
          default: d_addr = 32'($urandom_range(0, 63));
        endcase
      end
      if (!h_req && $urandom_range(0, 4) == 0) begin
        h_req = 1'b1;
        h_we = 1'($urandom_range(0, 1));
        h_addr = PC_BITS'($urandom_range(0, 63));
        h_wdata = $urandom;
      end
      cycle(0);
      if (last_gnt[2]) h_req = 1'b0;
      if (last_gnt[1]) d_req = 1'b0;
      if (last_gnt[0]) if_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
    cycle(0);
    cycle(0);
    cycle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minimax_mem_arbiter.md
Name: minimax_mem_arbiter

Overview:
- Shares one single-port synchronous 32-bit RAM among three requesters: the minimax instruction-fetch port, the minimax data port, and a host loader/debug port.
- Issues one RAM access per cycle using fixed priority plus a fetch-starvation guard.
- Routes the 1-cycle-latency read data back to the owning requester.
- Sits between the minimax core and program RAM, replacing the dual-port RAM arrangement.

Parameters:
- PC_BITS, 14, byte-address width of RAM space; RAM depth is 2^(PC_BITS-2) words.
- MAX_WAIT, 4, consecutive ungranted fetch cycles before fetch is promoted above data (range 1..15).
- EXIT_ADDR, 32'hFFFFFFFC, data-port address of the exit register (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  PC_BITS  fetch byte address; bit 0 ignored.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  16  fetched halfword.
- d_req  in  1  data request; held with d_* until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_wmask  in  4  byte enables for writes.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data granted (combinational).
- d_rvalid  out  1  data read valid.
- d_rdata  out  32  data read word.
- h_req  in  1  host request.
- h_we  in  1  host write; always full-word.
- h_addr  in  PC_BITS  host byte address.
- h_wdata  in  32  host write data.
- h_gnt  out  1  host granted (combinational).
- h_rvalid  out  1  host read valid.
- h_rdata  out  32  host read word.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  PC_BITS-2  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after a read.
- exit_valid  out  1  exit-register written (one-cycle pulse).
- exit_code  out  32  last value written to the exit register.

Behaviour:
- Arbitration is combinational each cycle. At most one gnt is high; gnt only when the matching req is high.
- Priority order: host > data > fetch.
- Promotion: when starve_cnt == MAX_WAIT and if_req is high, priority becomes host > fetch > data.
- starve_cnt (4-bit):
  - increments when if_req=1 and if_gnt=0, saturating at MAX_WAIT;
  - clears on if_gnt or when if_req=0.
- A granted access drives the RAM port in the same cycle.
  - ram_addr = addr[PC_BITS-1:2].
  - Data write: ram_we = d_wmask. Host write: ram_we = 4'hF. Reads: ram_we = 0.
  - With no grant: ram_en=0 and ram_we=0.
- Read return latency is exactly 1 cycle.
  - An owner tag register {none, fetch, data, host} and a halfword-select bit (if_addr[1]) are captured at grant.
  - The next cycle asserts the owner's rvalid for one cycle, with rdata taken from ram_rdata.
- if_rdata = ram_rdata[15:0] when the captured bit = 0, and ram_rdata[31:16] when it = 1 (little-endian).
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle; full throughput is 1 access/cycle.
- Out-of-range data address (d_addr[31:PC_BITS] != 0):
  - the access is granted, ram_en=0;
  - a write is dropped;
  - a read returns d_rvalid=1 with d_rdata=0 the next cycle.
- d_addr[1:0] are ignored; no misalignment fault.
- The rdata outputs hold their last value when rvalid=0.
- Reset (asynchronous, any time):
  - owner tag = none, starve_cnt = 0;
  - all rvalid = 0, exit_valid = 0, exit_code = 0, rdata registers = 0;
  - a read in flight is discarded and no rvalid is produced.
- All gnt and ram_* outputs are combinational from req and are 0 while reset_n=0.

Optional Feature:
- Macro: MINIMAX_MEM_EXIT_EN.
- When defined:
  - a granted data write with d_addr == EXIT_ADDR latches d_wdata into exit_code and pulses exit_valid high for the next cycle;
  - the write never reaches RAM (ram_en=0);
  - reads of EXIT_ADDR behave as out-of-range and return 0.
- When undefined: EXIT_ADDR is ordinary out-of-range space, exit_valid is tied 0 and exit_code is tied 0.

Test Plan:
- Single fetch, if_addr=0x0006, RAM word 1 = 0xBEEF1234 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0xBEEF.
- Data write d_addr=0x10, d_wmask=4'b0011, d_wdata=0xAABBCCDD over 0x11223344 -> ram_we=0011, ram_addr=4; a later data read returns 0x1122CCDD.
- if_req, d_req, h_req all high in the same cycle -> grant order host, then data, then fetch over three consecutive cycles; each rvalid arrives one cycle after its grant.
- d_req and if_req held continuously with MAX_WAIT=4 -> data is granted 4 cycles, fetch on the 5th, then data resumes; starve_cnt is back at 0 after the fetch grant.
- Data read granted, reset_n pulsed low before the next edge -> no d_rvalid after reset; all outputs are 0 during reset.
- With MINIMAX_MEM_EXIT_EN: data write 0x00000000 to 0xFFFFFFFC -> ram_en=0; next cycle exit_valid=1 for one cycle, exit_code=0. A write of 0xFFFFFFFF -> exit_code=0xFFFFFFFF. Without the macro, exit_valid stays 0.
